serial_seq_ctrl: RTL
====================

# serial_seq_ctrl

Parametrised control sequencer for the bit-serial datapath, driving operand shift, ALU op selection, carry handling and accumulator writeback over `DATA_W` serial cycles. The bit counter is internal, with no external counter block. The block latches the opcode at start, rejects illegal opcodes and reports `busy`/`done` to the instruction loader. An optional overlapped-writeback mode shortens each instruction.

## Interface
- `DATA_W`, default 8: serial operand width in bits; must be ≥ 2.
- `CNT_W`, default 3: bit-index width; must satisfy 2^CNT_W ≥ `DATA_W`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  4  instruction opcode; sampled only on an accepted start.
- `inst_valid`  in  1  full instruction loaded.
- `start`  in  1  one-cycle request pulse (debounced button edge).
- `abort`  in  1  synchronous cancel.
- `busy`  out  1  high in EXEC and WB.
- `done`  out  1  one-cycle pulse on completion.
- `illegal`  out  1  one-cycle pulse when a start is rejected.
- `reg_shift_en`  out  1  shift register-file operand.
- `imm_sel`  out  1  B operand from the immediate shifter; I-type.
- `imm_shift_en`  out  1  shift the immediate.
- `acc_shift_en`  out  1  shift the accumulator.
- `acc_write_en`  out  1  load the ALU result bit into the accumulator.
- `alu_op`  out  2  00 add, 01 xor, 10 and, 11 or.
- `sub_en`  out  1  invert B; carry-in 1.
- `carry_en`  out  1  carry flop update enable.
- `carry_load`  out  1  load the carry flop with `sub_en`; first EXEC cycle.
- `bit_idx`  out  CNT_W  current bit, LSB first.
- `last_bit`  out  1  `bit_idx == DATA_W-1` in EXEC or WB.

## Operation
**States:**
- IDLE: entered on reset.
- EXEC
- WB
- DONE

**Opcode decode** (opcode[3]=1 is I-type):

| Opcode | Instruction | Decoded outputs |
|---|---|---|
| 0000 | ADD | alu_op 00 |
| 0001 | SUB | alu_op 00, sub_en=1 |
| 0110 | XOR | alu_op 01 |
| 0101 | AND | alu_op 10 |
| 0100 | OR | alu_op 11 |
| 1000 | ADDI | alu_op 00 |
| 1001 | SUBI | alu_op 00, sub_en=1 |
| 1100 | XORI | alu_op 01 |
| 1011 | ANDI | alu_op 10 |
| 1010 | ORI | alu_op 11 |

- All other opcodes are illegal.

**Transitions and outputs by state:**
- IDLE → EXEC when `start && inst_valid` and the opcode is legal. The opcode is latched into an internal register at that edge.
- `start && inst_valid` with an illegal opcode: `illegal`=1 the next cycle, state stays IDLE.
- `start` without `inst_valid` is ignored.
- `start` in any state other than IDLE is ignored; no queuing.
- EXEC, `DATA_W` cycles:
  - `reg_shift_en`=1 and `carry_en`=1.
  - `imm_shift_en`=`imm_sel`=latched opcode[3].
  - `alu_op` and `sub_en` come from the latched opcode.
  - `carry_load`=1 only at `bit_idx`=0.
- On `last_bit`, EXEC → WB.
- WB, `DATA_W` cycles: `acc_write_en`=`acc_shift_en`=1.
- On `last_bit`, WB → DONE.
- DONE, one cycle: `done`=1, then IDLE.

**Bit counter:**
- Cleared in IDLE and DONE.
- Increments each EXEC/WB cycle.
- Wraps to 0 on `last_bit`.
- Never exceeds `DATA_W-1`.

**Abort:**
- In EXEC or WB: next state IDLE, counter cleared, no `done`, all enables low from the next cycle.
- In IDLE or DONE: no effect.

**Reset:**
- Asserting `rst_n` low at any time forces IDLE, counter 0, latched opcode 0, and every output 0 immediately.
- `alu_op`=00 and `bit_idx`=0 during reset.

## Timing
- Start accepted at edge N: EXEC during cycles N+1 … N+DATA_W.
- WB occupies the next `DATA_W` cycles.
- `done` is high in cycle N+2·DATA_W+1.
- `busy` is high exactly for EXEC and WB cycles.
- All outputs are combinational from state, counter and latched opcode; there is no extra output register stage.
- Changing `opcode` after acceptance has no effect.
- A new start is accepted in DONE+1 (IDLE) at the earliest; minimum issue interval is 2·DATA_W+2 cycles.

## Configuration
- Macro `SERIAL_SEQ_OVERLAP_WB_EN`, when defined:
  - EXEC also asserts `acc_write_en`=`acc_shift_en`=1.
  - WB is never entered: EXEC on `last_bit` → DONE.
  - `done` at N+DATA_W+1.
  - Minimum issue interval is DATA_W+2.
- When undefined: the separate-WB behaviour above applies.
- The WB state encoding exists in both builds.

## Test plan
- Reset with `DATA_W`=8, `rst_n` low mid-EXEC → all outputs 0 asynchronously, IDLE after release, no `done`.
- ADD (0000), `start` at edge N → `reg_shift_en` high for 8 cycles, `carry_load` only in the first, `acc_write_en` for 8 cycles, `done` at N+17.
- SUBI (1001) → `sub_en`=1, `imm_sel`=`imm_shift_en`=1, `carry_load` at `bit_idx` 0.
- Opcode 0111 with `start` → `illegal` pulse, `busy` stays 0; a second `start` while busy is ignored.
- `abort` at `bit_idx`=3 of WB → IDLE next cycle, no `done`; `DATA_W`=16 ADD → `done` at N+33, `bit_idx` wraps 15→0.
- `SERIAL_SEQ_OVERLAP_WB_EN` defined, XOR (0110), `DATA_W`=8 → `acc_write_en` concurrent with `reg_shift_en`, `done` at N+9.

Source files
------------

// File: rtl/serial_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_seq_ctrl_if
// Bundles the instruction-loader handshake and the datapath control strobes
// of the bit-serial sequencer into one port.
//
// Parameters:
//   CNT_W      bit-index width; it must match the sequencer's CNT_W
//
// Signals (direction seen from the sequencer, i.e. the slave modport):
//   opcode       in   4      instruction opcode, sampled on an accepted start
//   inst_valid   in   1      a full instruction is loaded
//   start        in   1      one-cycle start request
//   abort        in   1      synchronous cancel
//   busy         out  1      sequencer is in EXEC or WB
//   done         out  1      one-cycle completion pulse
//   illegal      out  1      one-cycle pulse for a rejected start
//   reg_shift_en out  1      shift the register-file operand
//   imm_sel      out  1      take the B operand from the immediate shifter
//   imm_shift_en out  1      shift the immediate
//   acc_shift_en out  1      shift the accumulator
//   acc_write_en out  1      load the ALU result bit into the accumulator
//   alu_op       out  2      00 add, 01 xor, 10 and, 11 or
//   sub_en       out  1      invert B and force carry-in to 1
//   carry_en     out  1      carry flop update enable
//   carry_load   out  1      load the carry flop with sub_en
//   bit_idx      out  CNT_W  current bit, LSB first
//   last_bit     out  1      current bit is the final one of the operand
// -----------------------------------------------------------------------------
interface serial_seq_ctrl_if #(
  parameter int CNT_W = 3
);
  logic [3:0]       opcode;
  logic             inst_valid;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             reg_shift_en;
  logic             imm_sel;
  logic             imm_shift_en;
  logic             acc_shift_en;
  logic             acc_write_en;
  logic [1:0]       alu_op;
  logic             sub_en;
  logic             carry_en;
  logic             carry_load;
  logic [CNT_W-1:0] bit_idx;
  logic             last_bit;

  // The instruction loader / testbench side.
  modport master (
    output opcode, inst_valid, start, abort,
    input  busy, done, illegal, reg_shift_en, imm_sel, imm_shift_en,
           acc_shift_en, acc_write_en, alu_op, sub_en, carry_en,
           carry_load, bit_idx, last_bit
  );

  // The sequencer side.
  modport slave (
    input  opcode, inst_valid, start, abort,
    output busy, done, illegal, reg_shift_en, imm_sel, imm_shift_en,
           acc_shift_en, acc_write_en, alu_op, sub_en, carry_en,
           carry_load, bit_idx, last_bit
  );
endinterface

// File: rtl/serial_seq_ctrl.sv
// -----------------------------------------------------------------------------
// serial_seq_ctrl
// Control sequencer for the bit-serial datapath. A legal instruction is
// latched at start, then DATA_W EXEC cycles shift the operands through the
// ALU and DATA_W WB cycles shift the result into the accumulator, followed
// by a single DONE cycle. The bit counter lives inside this block.
//
// Parameters:
//   DATA_W  serial operand width in bits (>= 2)
//   CNT_W   bit-index width, 2**CNT_W >= DATA_W
//
// Ports:
//   clk     in     system clock, rising edge
//   rst_n   in     asynchronous active-low reset
//   bus     slave  serial_seq_ctrl_if: loader handshake + datapath strobes
//
// Build option:
//   SERIAL_SEQ_OVERLAP_WB_EN  when defined, the accumulator is written during
//                             EXEC and the WB state is skipped.
// -----------------------------------------------------------------------------
module serial_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bitIdx_q, bitIdx_d;
  logic [3:0]       opLatch_q, opLatch_d;
  logic             illegal_q, illegal_d;

  logic inExec;
  logic inWb;
  logic lastBit;

  // Opcode decode. The encoding is sparse, so everything outside the ten
  // listed instructions is rejected at start.
  function automatic logic isLegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0110, 4'b0101, 4'b0100,
      4'b1000, 4'b1001, 4'b1100, 4'b1011, 4'b1010: isLegal = 1'b1;
      default:                                      isLegal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] aluOf(input logic [3:0] op);
    case (op)
      4'b0110, 4'b1100: aluOf = 2'b01;
      4'b0101, 4'b1011: aluOf = 2'b10;
      4'b0100, 4'b1010: aluOf = 2'b11;
      default:          aluOf = 2'b00;
    endcase
  endfunction

  function automatic logic subOf(input logic [3:0] op);
    subOf = (op == 4'b0001) || (op == 4'b1001);
  endfunction

  assign inExec  = (state_q == ST_EXEC);
  assign inWb    = (state_q == ST_WB);
  assign lastBit = (inExec || inWb) && (bitIdx_q == LAST_IDX);

  // Next-state logic. Abort takes priority over the last-bit transition, so
  // an abort on the final bit still suppresses done. The counter wraps to 0
  // on the last bit so the following phase starts at bit 0.
  always_comb begin
    state_d   = state_q;
    bitIdx_d  = bitIdx_q;
    opLatch_d = opLatch_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bitIdx_d = '0;
        if (bus.start && bus.inst_valid) begin
          if (isLegal(bus.opcode)) begin
            state_d   = ST_EXEC;
            opLatch_d = bus.opcode;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          bitIdx_d = '0;
        end else if (lastBit) begin
          bitIdx_d = '0;
`ifdef SERIAL_SEQ_OVERLAP_WB_EN
          state_d  = ST_DONE;
`else
          state_d  = ST_WB;
`endif
        end else begin
          bitIdx_d = bitIdx_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          bitIdx_d = '0;
        end else if (lastBit) begin
          state_d  = ST_DONE;
          bitIdx_d = '0;
        end else begin
          bitIdx_d = bitIdx_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bitIdx_d = '0;
      end
    endcase
  end

  // State, counter, latched opcode and the delayed illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bitIdx_q  <= '0;
      opLatch_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitIdx_q  <= bitIdx_d;
      opLatch_q <= opLatch_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath strobes decode straight from state, counter and latched opcode.
  // ALU controls are gated to EXEC so they read as zero whenever idle or in
  // reset.
  always_comb begin
    bus.busy         = inExec || inWb;
    bus.done         = (state_q == ST_DONE);
    bus.illegal      = illegal_q;
    bus.reg_shift_en = inExec;
    bus.carry_en     = inExec;
    bus.carry_load   = inExec && (bitIdx_q == '0);
    bus.imm_sel      = inExec && opLatch_q[3];
    bus.imm_shift_en = inExec && opLatch_q[3];
    bus.alu_op       = inExec ? aluOf(opLatch_q) : 2'b00;
    bus.sub_en       = inExec && subOf(opLatch_q);
`ifdef SERIAL_SEQ_OVERLAP_WB_EN
    bus.acc_write_en = inExec || inWb;
    bus.acc_shift_en = inExec || inWb;
`else
    bus.acc_write_en = inWb;
    bus.acc_shift_en = inWb;
`endif
    bus.bit_idx      = bitIdx_q;
    bus.last_bit     = lastBit;
  end

endmodule
